spi_flash_reader: RTL

- Standalone SPI-flash read initiator: the master side of the single-bit SPI read protocol the `spiflash` behavioural model answers.
- Accepts a (24-bit byte address, word count) request and issues a legacy READ (0x03) transaction.
- Returns little-endian 32-bit words through a valid/ready stream.
- Used by user-project logic to pull tables or firmware images from the external flash; verified directly against the `spiflash` model in Caravel-style benches.

---
 rtl/spi_flash_pkg.sv | 17 +
 rtl/spi_sck_gen.sv | 47 ++++
 rtl/spi_flash_reader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared constants for the SPI flash read initiator
package spi_flash_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_CMD   = 3'd2;
    localparam logic [2:0] ST_ADDR  = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STALL = 3'd5;
    localparam logic [2:0] ST_TAIL  = 3'd6;
    localparam logic [2:0] ST_GAP   = 3'd7;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam int         ADDR_W   = 24;
    localparam int         WORD_W   = 32;

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK divider with one-cycle rise/fall strobes and a hold-low input
module spi_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic hold,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    logic       tick;

    assign tick = (cnt_q == DIV_LAST);
    // Strobes mark the clock edge at which sck itself toggles.
    assign rise = !hold && tick && !sck_q;
    assign fall = !hold && tick && sck_q;
    assign sck  = sck_q;

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        sck_d = sck_q;
        if (hold) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            sck_d = !sck_q;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI flash READ (0x03) initiator returning little-endian 32-bit words
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_IDLE = 4
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              flash_csb,
    output logic              flash_clk,
    output logic              flash_io0,
    input  logic              flash_io1
);

    localparam logic [7:0] TAIL_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST  = 8'(CS_IDLE - 1);

    logic [2:0]          state_q, state_d;
    logic                csb_q, csb_d;
    logic [ADDR_W+7:0]   sh_out_q, sh_out_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [6:0]          byte_q, byte_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                word_rdy_q, word_rdy_d;
    logic [7:0]          words_left_q, words_left_d;
    logic [7:0]          wait_q, wait_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_last_q, rsp_last_d;

    logic       sck_hold, sck_rise, sck_fall;
    logic       out_free, load;
    logic [7:0] new_byte;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clock  (clock),
        .resetb (resetb),
        .hold   (sck_hold),
        .sck    (flash_clk),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    assign sck_hold  = (state_q == ST_IDLE) || (state_q == ST_STALL) ||
                       (state_q == ST_TAIL) || (state_q == ST_GAP);
    assign out_free  = !rsp_valid_q || rsp_ready;
    assign new_byte  = {byte_q, flash_io1};
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign flash_csb = csb_q;
    assign flash_io0 = sh_out_q[ADDR_W+7];
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;

    always_comb begin
        state_d      = state_q;
        csb_d        = csb_q;
        sh_out_d     = sh_out_q;
        bit_cnt_d    = bit_cnt_q;
        byte_d       = byte_q;
        word_d       = word_q;
        word_rdy_d   = word_rdy_q;
        words_left_d = words_left_q;
        wait_d       = wait_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_last_d   = rsp_last_q;
        load         = 1'b0;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
        end
        // Zeros shift in behind the header, so MOSI idles low once it is sent.
        if (sck_fall) sh_out_d = {sh_out_q[ADDR_W+6:0], 1'b0};
        if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            byte_d    = new_byte[6:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_len != 8'd0) begin
                    state_d      = ST_SETUP;
                    csb_d        = 1'b0;
                    sh_out_d     = {CMD_READ, req_addr};
                    words_left_d = req_len;
                    bit_cnt_d    = '0;
                    word_rdy_d   = 1'b0;
                end
            end
            ST_SETUP: if (sck_rise) state_d = ST_CMD;
            ST_CMD:   if (sck_rise && bit_cnt_q == 6'd7) state_d = ST_ADDR;
            ST_ADDR: begin
                if (sck_rise && bit_cnt_q == 6'd31) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (sck_rise) begin
                    if (bit_cnt_q[2:0] == 3'd7) word_d = {new_byte, word_q[WORD_W-1:8]};
                    if (bit_cnt_q == 6'd31) begin
                        bit_cnt_d  = '0;
                        word_rdy_d = 1'b1;
                    end
                end
                if (sck_fall && word_rdy_q) begin
                    word_rdy_d = 1'b0;
                    if (out_free) load = 1'b1;
                    else          state_d = ST_STALL;
                end
            end
            ST_STALL: if (out_free) load = 1'b1;
            ST_TAIL: begin
                if (wait_q == 8'd0) begin
                    csb_d   = 1'b1;
                    state_d = ST_GAP;
                    wait_d  = GAP_LAST;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (wait_q == 8'd0) state_d = ST_IDLE;
                else                wait_d  = wait_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = word_q;
            rsp_last_d   = (words_left_q == 8'd1);
            words_left_d = words_left_q - 8'd1;
            if (words_left_q == 8'd1) begin
                state_d = ST_TAIL;
                wait_d  = TAIL_LAST;
            end else begin
                state_d = ST_DATA;
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            csb_q        <= 1'b1;
            sh_out_q     <= '0;
            bit_cnt_q    <= '0;
            byte_q       <= '0;
            word_q       <= '0;
            word_rdy_q   <= 1'b0;
            words_left_q <= '0;
            wait_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            csb_q        <= csb_d;
            sh_out_q     <= sh_out_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_q       <= byte_d;
            word_q       <= word_d;
            word_rdy_q   <= word_rdy_d;
            words_left_q <= words_left_d;
            wait_q       <= wait_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_last_q   <= rsp_last_d;
        end
    end

endmodule
